// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared 16:1 mux.
// Grants are registered, held until done/withdraw/hold-limit, then rotated without a bubble.
module mux_sel_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] req_i,
   input  logic        done_i,
   output logic [3:0]  sel_o,
   output logic [15:0] gnt_o,
   output logic        gnt_valid_o,
   output logic        preempt_o
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e      state_q, state_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [7:0]  hold_q, hold_d;
   logic [3:0]  sel_q, sel_d;
   logic [15:0] gnt_q, gnt_d;
   logic        valid_q, valid_d;
   logic        preempt_q, preempt_d;

   logic [3:0]  search_start;
   logic [3:0]  idx;
   logic [3:0]  winner;
   logic        found;
   logic        hold_max;
   logic        rel_now;

   // Circular first-one search; after a release the old owner is scanned last.
   always_comb begin
      search_start = (state_q == StIdle) ? ptr_q : sel_q + 4'd1;
      found        = 1'b0;
      winner       = 4'd0;
      idx          = 4'd0;
      for (int i = 0; i < 16; i++) begin
         idx = search_start + 4'(i);
         if (!found && req_i[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   assign hold_max = (hold_q == 8'(MAX_HOLD));
   assign rel_now  = done_i | ~req_i[sel_q] | hold_max;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         ptr_q     <= 4'd0;
         hold_q    <= 8'd0;
         sel_q     <= 4'd0;
         gnt_q     <= 16'd0;
         valid_q   <= 1'b0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         sel_q     <= sel_d;
         gnt_q     <= gnt_d;
         valid_q   <= valid_d;
         preempt_q <= preempt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      sel_d     = sel_q;
      gnt_d     = gnt_q;
      valid_d   = valid_q;
      preempt_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            gnt_d   = 16'd0;
            valid_d = 1'b0;
            if (found) begin
               state_d = StGrant;
               sel_d   = winner;
               gnt_d   = 16'd1 << winner;
               valid_d = 1'b1;
               hold_d  = 8'd1;
            end
         end
         StGrant: begin
            if (rel_now) begin
               ptr_d     = sel_q + 4'd1;
               preempt_d = hold_max & ~done_i & req_i[sel_q];
               if (found) begin
                  sel_d  = winner;
                  gnt_d  = 16'd1 << winner;
                  hold_d = 8'd1;
               end else begin
                  state_d = StIdle;
                  gnt_d   = 16'd0;
                  valid_d = 1'b0;
                  hold_d  = 8'd0;
               end
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      sel_o       = sel_q;
      gnt_o       = gnt_q;
      gnt_valid_o = valid_q;
      preempt_o   = preempt_q;
   end

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Directed bench for mux_sel_rr_arbiter with hand-computed expectations (MAX_HOLD = 8).
module tb_mux_sel_rr_arbiter;

   logic        clk;
   logic        rst;
   logic [15:0] req_i;
   logic        done_i;
   logic [3:0]  sel_o;
   logic [15:0] gnt_o;
   logic        gnt_valid_o;
   logic        preempt_o;

   int unsigned n_tests;
   int unsigned n_fail;

   mux_sel_rr_arbiter #(.MAX_HOLD(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req_i),
      .done_i     (done_i),
      .sel_o      (sel_o),
      .gnt_o      (gnt_o),
      .gnt_valid_o(gnt_valid_o),
      .preempt_o  (preempt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      req_i  = 16'h0;
      done_i = 1'b0;
      rst    = 1'b1;
      #2;
      rst    = 1'b0;
   endtask

   task automatic check_grant(input string tag, input logic [3:0] s, input logic p);
      check({tag, ".sel"}, 32'(sel_o), 32'(s));
      check({tag, ".gnt"}, 32'(gnt_o), 32'(16'd1 << s));
      check({tag, ".vld"}, 32'(gnt_valid_o), 32'd1);
      check({tag, ".pre"}, 32'(preempt_o), 32'(p));
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      req_i   = 16'h0;
      done_i  = 1'b0;
      #1;
      check("rst.sel", 32'(sel_o), 32'd0);
      check("rst.gnt", 32'(gnt_o), 32'd0);
      check("rst.vld", 32'(gnt_valid_o), 32'd0);
      check("rst.pre", 32'(preempt_o), 32'd0);
      #2;
      rst = 1'b0;

      // Single requester, then asynchronous reset mid-grant.
      req_i = 16'h0001;
      step();
      check_grant("g0", 4'd0, 1'b0);
      rst = 1'b1;
      #1;
      check("arst.gnt", 32'(gnt_o), 32'd0);
      check("arst.vld", 32'(gnt_valid_o), 32'd0);
      check("arst.sel", 32'(sel_o), 32'd0);
      #1;
      rst = 1'b0;

      // done every cycle: rotation 0, 8, 15, 0, 8 with no bubble.
      do_reset();
      req_i = 16'h8101;
      step();
      check_grant("rr0", 4'd0, 1'b0);
      done_i = 1'b1;
      step();
      check_grant("rr1", 4'd8, 1'b0);
      step();
      check_grant("rr2", 4'd15, 1'b0);
      step();
      check_grant("rr3", 4'd0, 1'b0);
      step();
      check_grant("rr4", 4'd8, 1'b0);

      // Sole requester hits hold limit: re-granted with a preempt pulse.
      do_reset();
      req_i = 16'h0010;
      for (int i = 1; i <= 8; i++) begin
         step();
         check_grant($sformatf("sole%0d", i), 4'd4, 1'b0);
      end
      step();
      check_grant("sole_pre", 4'd4, 1'b1);
      step();
      check_grant("sole_post", 4'd4, 1'b0);

      // Two requesters alternate every 8 cycles.
      do_reset();
      req_i = 16'h0011;
      step();
      check_grant("alt1", 4'd0, 1'b0);
      for (int i = 2; i <= 8; i++) step();
      check_grant("alt8", 4'd0, 1'b0);
      step();
      check_grant("alt9", 4'd4, 1'b1);
      step();
      check_grant("alt10", 4'd4, 1'b0);
      for (int i = 11; i <= 16; i++) step();
      check_grant("alt16", 4'd4, 1'b0);
      step();
      check_grant("alt17", 4'd0, 1'b1);
      // done coinciding with the limit suppresses the pulse.
      for (int i = 18; i <= 24; i++) step();
      done_i = 1'b1;
      step();
      check_grant("alt25", 4'd4, 1'b0);
      done_i = 1'b0;

      // Withdrawal to idle keeps sel; new request searches from ptr=5.
      do_reset();
      req_i = 16'h0010;
      step();
      check_grant("wd0", 4'd4, 1'b0);
      req_i = 16'h0000;
      step();
      check("wd.vld", 32'(gnt_valid_o), 32'd0);
      check("wd.gnt", 32'(gnt_o), 32'd0);
      check("wd.sel", 32'(sel_o), 32'd4);
      check("wd.pre", 32'(preempt_o), 32'd0);
      done_i = 1'b1;
      step();
      check("idle_done.vld", 32'(gnt_valid_o), 32'd0);
      done_i = 1'b0;
      req_i  = 16'h0008;
      step();
      check_grant("wd3", 4'd3, 1'b0);

      // Wrap from owner 15.
      do_reset();
      req_i = 16'h8000;
      step();
      check_grant("wr0", 4'd15, 1'b0);
      req_i  = 16'h8002;
      done_i = 1'b1;
      step();
      check_grant("wr1", 4'd1, 1'b0);
      check("wr.ptr", 32'(dut.ptr_q), 32'd0);
      done_i = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
